// File: rtl/ex_muldiv_if.sv
// ex_muldiv_if -- EX-stage handshake between the ID/EX register / ctrl and the
// RV32M multiply/divide unit.
//   stall      : pipeline stall vector from ctrl (only bit 3, EX hold, is used)
//   alu_op     : operation code from ID/EX
//   reg1, reg2 : rs1 / rs2 operands from ID/EX
//   mdu_result : M-extension result, meaningful while mdu_valid = 1
//   mdu_valid  : result ready this cycle
//   stall_req  : combinational request to ctrl to hold IF/ID/EX
// master = pipeline side, slave = multiply/divide unit.
`ifndef RegLen
`define RegLen 32
`endif
`ifndef ALU_Len
`define ALU_Len 8
`endif

interface ex_muldiv_if;
  logic [5:0]            stall;
  logic [`ALU_Len-1:0]   alu_op;
  logic [`RegLen-1:0]    reg1;
  logic [`RegLen-1:0]    reg2;
  logic [`RegLen-1:0]    mdu_result;
  logic                  mdu_valid;
  logic                  stall_req;

  modport master (
    output stall, alu_op, reg1, reg2,
    input  mdu_result, mdu_valid, stall_req
  );

  modport slave (
    input  stall, alu_op, reg1, reg2,
    output mdu_result, mdu_valid, stall_req
  );
endinterface

// File: rtl/ex_muldiv.sv
// ex_muldiv -- iterative RV32M multiply/divide unit for the EX stage.
// Multiplies by 32-step shift-add and divides by 32-step restoring division on
// operand magnitudes, fixing the sign at the end. Divide-by-zero and signed
// overflow finish in one cycle without iterating.
//   clk : rising-edge clock
//   rst : synchronous reset, active low
//   bus : ex_muldiv_if.slave (stall, alu_op, reg1, reg2 in;
//         mdu_result, mdu_valid, stall_req out)
`ifndef RegLen
`define RegLen 32
`endif
`ifndef ALU_Len
`define ALU_Len 8
`endif
`ifndef NoAlu
`define NoAlu  8'h00
`define MUL    8'h30
`define MULH   8'h31
`define MULHSU 8'h32
`define MULHU  8'h33
`define DIV    8'h34
`define DIVU   8'h35
`define REM    8'h36
`define REMU   8'h37
`endif

module ex_muldiv (
  input  logic         clk,
  input  logic         rst,
  ex_muldiv_if.slave   bus
);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_e;

  state_e              state_q, state_d;
  logic [4:0]          cnt_q, cnt_d;
  logic [`ALU_Len-1:0] op_q, op_d;
  logic [31:0]         a_q, a_d;        // |rs1|: multiplicand
  logic [31:0]         b_q, b_d;        // |rs2|: divisor
  logic [31:0]         rem_q, rem_d;
  logic [63:0]         prod_q, prod_d;  // product, or quotient in the low word
  logic                neg_q, neg_d;    // product / quotient sign
  logic                rneg_q, rneg_d;  // remainder sign (dividend sign)
  logic [31:0]         result_q, result_d;

  logic unused_stall_bits;
  assign unused_stall_bits = ^{bus.stall[5:4], bus.stall[2:0]};

  function automatic logic is_mul(input logic [`ALU_Len-1:0] op);
    return (op == `MUL) || (op == `MULH) || (op == `MULHSU) || (op == `MULHU);
  endfunction

  function automatic logic is_div(input logic [`ALU_Len-1:0] op);
    return (op == `DIV) || (op == `DIVU) || (op == `REM) || (op == `REMU);
  endfunction

  // ---------------- input decode (start cycle only) ----------------
  logic        mdu_op, in_mul, in_div;
  logic        a_neg, b_neg, div_zero, div_ovf, bypass;
  logic [31:0] a_mag, b_mag, bypass_res;

  always_comb begin
    in_mul   = is_mul(bus.alu_op);
    in_div   = is_div(bus.alu_op);
    mdu_op   = in_mul || in_div;
    a_neg    = ((bus.alu_op == `MULH) || (bus.alu_op == `MULHSU) ||
                (bus.alu_op == `DIV)  || (bus.alu_op == `REM)) && bus.reg1[31];
    b_neg    = ((bus.alu_op == `MULH) || (bus.alu_op == `DIV) ||
                (bus.alu_op == `REM)) && bus.reg2[31];
    a_mag    = a_neg ? (32'd0 - bus.reg1) : bus.reg1;
    b_mag    = b_neg ? (32'd0 - bus.reg2) : bus.reg2;
    div_zero = in_div && (bus.reg2 == '0);
    div_ovf  = ((bus.alu_op == `DIV) || (bus.alu_op == `REM)) &&
               (bus.reg1 == 32'h8000_0000) && (bus.reg2 == '1);
    bypass   = div_zero || div_ovf;
    if ((bus.alu_op == `DIV) || (bus.alu_op == `DIVU))
      bypass_res = div_zero ? '1 : 32'h8000_0000;
    else
      bypass_res = div_zero ? bus.reg1 : '0;
  end

  // ---------------- one iteration on the latched copies ----------------
  logic [32:0] mul_sum;
  logic [63:0] mul_next, mul_signed;
  logic [32:0] div_shift;
  logic [33:0] div_diff;
  logic        div_ge;
  logic [31:0] div_rem_next, div_quo_next, quo_signed, rem_signed, final_res;

  always_comb begin
    mul_sum      = {1'b0, prod_q[63:32]} + (prod_q[0] ? {1'b0, a_q} : 33'd0);
    mul_next     = {mul_sum, prod_q[31:1]};
    div_shift    = {rem_q, prod_q[31]};
    div_diff     = {1'b0, div_shift} - {2'b00, b_q};
    div_ge       = ~div_diff[33];
    div_rem_next = div_ge ? div_diff[31:0] : div_shift[31:0];
    div_quo_next = {prod_q[30:0], div_ge};
    mul_signed   = neg_q  ? (64'd0 - mul_next)     : mul_next;
    quo_signed   = neg_q  ? (32'd0 - div_quo_next) : div_quo_next;
    rem_signed   = rneg_q ? (32'd0 - div_rem_next) : div_rem_next;
    if (op_q == `MUL)
      final_res = mul_signed[31:0];
    else if (is_mul(op_q))
      final_res = mul_signed[63:32];
    else if ((op_q == `DIV) || (op_q == `DIVU))
      final_res = quo_signed;
    else
      final_res = rem_signed;
  end

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (mdu_op) state_d = bypass ? DONE : BUSY;
      BUSY: if (cnt_q == 5'd31) state_d = DONE;
      DONE: if (!bus.stall[3]) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    bus.stall_req = 1'b0;
    bus.mdu_valid = 1'b0;
    unique case (state_q)
      IDLE:    bus.stall_req = mdu_op;
      BUSY:    bus.stall_req = 1'b1;
      DONE:    bus.mdu_valid = 1'b1;
      default: ;
    endcase
  end

  assign bus.mdu_result = result_q;

  // ---------------- datapath next state ----------------
  always_comb begin
    cnt_d    = cnt_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    rem_d    = rem_q;
    prod_d   = prod_q;
    neg_d    = neg_q;
    rneg_d   = rneg_q;
    result_d = result_q;
    if ((state_q == IDLE) && mdu_op) begin
      op_d   = bus.alu_op;
      a_d    = a_mag;
      b_d    = b_mag;
      neg_d  = a_neg ^ b_neg;
      rneg_d = a_neg;
      cnt_d  = '0;
      rem_d  = '0;
      // Low word seeds the multiplier for MUL*, the dividend for DIV*/REM*.
      prod_d = {32'd0, in_mul ? b_mag : a_mag};
      if (bypass) result_d = bypass_res;
    end else if (state_q == BUSY) begin
      cnt_d = cnt_q + 5'd1;
      if (is_mul(op_q)) begin
        prod_d = mul_next;
      end else begin
        prod_d = {prod_q[63:32], div_quo_next};
        rem_d  = div_rem_next;
      end
      if (cnt_q == 5'd31) result_d = final_res;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q    <= '0;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      rem_q    <= '0;
      prod_q   <= '0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      result_q <= '0;
    end else begin
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      rem_q    <= rem_d;
      prod_q   <= prod_d;
      neg_q    <= neg_d;
      rneg_q   <= rneg_d;
      result_q <= result_d;
    end
  end

endmodule

// File: doc/ex_muldiv.md
EX_MULDIV -- requirements
Module: ex_muldiv

Interface
REQ-001 SHALL have no parameters; widths come from config.vh (`RegLen = 32, `ALU_Len), and the eight RV32M op codes `MUL, `MULH, `MULHSU, `MULHU, `DIV, `DIVU, `REM, `REMU are added there.
REQ-002 SHALL use one clock; reset is synchronous and active-low.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 rst  input  1  synchronous reset, active low (rst == 0 resets).
REQ-005 stall  input  6  pipeline stall vector from ctrl; only stall[3] (EX hold) is used.
REQ-006 alu_op  input  `ALU_Len  operation from the ID/EX register.
REQ-007 reg1  input  32  rs1 operand from the ID/EX register.
REQ-008 reg2  input  32  rs2 operand from the ID/EX register.
REQ-009 mdu_result  output  32  result of the M-extension operation; meaningful only while mdu_valid = 1.
REQ-010 mdu_valid  output  1  result is ready this cycle; EX selects mdu_result over the ALU result.
REQ-011 stall_req  output  1  combinational request to ctrl to hold IF/ID/EX.

Function
REQ-012 SHALL implement FSM states IDLE, BUSY and DONE, plus a 5-bit iteration counter.
REQ-013 mdu_op is true when alu_op is one of the eight RV32M codes; any other alu_op (including `NoAlu bubbles) leaves the FSM in IDLE with stall_req = 0.
REQ-014 IDLE with mdu_op: latch the operation, operand magnitudes and result sign into internal registers, clear the counter, and go to BUSY.
REQ-015 BUSY: perform one iteration per cycle; after 32 iterations (counter 31 to 0 wrap), go to DONE.
REQ-016 Multiply: 32-step shift-add on magnitudes into a 64-bit product, then negate if the result sign is set.
- MUL returns the low word.
- MULH, MULHSU and MULHU return the high word.
REQ-017 Operand signedness:
- MULH, DIV and REM: both operands signed.
- MULHSU: rs1 signed, rs2 unsigned.
- MULHU, DIVU and REMU: both operands unsigned.
REQ-018 Divide: 32-step restoring division on magnitudes.
- Quotient is negated when the operand signs differ.
- Remainder takes the sign of the dividend.
REQ-019 Divide by zero SHALL bypass BUSY (IDLE to DONE in one cycle):
- DIV and DIVU return 0xFFFFFFFF.
- REM and REMU return the original dividend.
REQ-020 Signed overflow (DIV or REM with reg1 = 0x80000000 and reg2 = 0xFFFFFFFF) SHALL bypass BUSY:
- DIV returns 0x80000000.
- REM returns 0x00000000.
REQ-021 stall_req = (state == IDLE and mdu_op) or (state == BUSY); it is 0 in DONE.
REQ-022 DONE: mdu_valid = 1 and mdu_result is held from a register.
- Leave DONE for IDLE on the first edge where stall[3] == 0.
- While stall[3] == 1 (downstream hold), remain in DONE and do not restart.
REQ-023 Latency: normal operation asserts stall_req for 33 cycles, then DONE lasts ≥1 cycle; the total is 34 cycles when there is no downstream stall.
REQ-024 The inputs are held stable by ID/EX while stall_req = 1; the block SHALL still use only the latched copies after the start cycle.
REQ-025 Back-to-back M ops: after DONE to IDLE, a new mdu_op in the following cycle SHALL start immediately with no idle gap.

Reset
REQ-026 When rst == 0 at a clock edge, the block SHALL reset to:
- state IDLE;
- counter 0;
- mdu_result 0x00000000;
- mdu_valid 0;
- all internal operand, product and remainder registers 0.
REQ-027 A reset in BUSY or DONE SHALL abandon the operation; stall_req becomes 0 in the cycle after the reset edge unless alu_op is an M op.

Verification
REQ-028 MUL reg1 = 7, reg2 = 0xFFFFFFFD -> stall_req high for 33 cycles, then mdu_valid = 1 with mdu_result = 0xFFFFFFEB.
REQ-029 MULHU 0xFFFFFFFF × 0xFFFFFFFF -> 0xFFFFFFFE; MULH with the same operands -> 0x00000000; MULHSU 0xFFFFFFFF × 2 -> 0xFFFFFFFF.
REQ-030 DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD; REM with the same operands -> 0xFFFFFFFF; DIVU 100 / 7 -> 14; REMU 100 / 7 -> 2.
REQ-031 Corner cases, each reaching DONE one cycle after start:
- DIVU 5 / 0 -> 0xFFFFFFFF.
- REM 5 / 0 -> 5.
- DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000.
REQ-032 stall[3] forced high for 3 cycles during DONE -> mdu_valid stays 1, mdu_result is stable, and there is no restart; then a back-to-back MUL 3 × 4 -> 12.
REQ-033 rst = 0 asserted at iteration 10 of a DIV -> the next cycle has mdu_valid = 0, mdu_result = 0, state IDLE, and stall_req = 0 with alu_op = `NoAlu.
